// File: rtl/alu_pkg.sv
// Shared opcode encodings, multi-cycle FSM state type and iteration count
// used by the ALU top level and its multi-cycle engine.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_DIV = 3'b101;

    localparam int unsigned ALU_ITERS = 32;
    localparam logic [4:0]  ALU_LAST_ITER = 5'(ALU_ITERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mc_state_t;

endpackage

// File: rtl/alu_mcycle.sv
// Iterative unsigned MUL (shift-add) and DIV (restoring) engine sharing one
// 34-bit adder; drives the stall signal and the held multi-cycle result.
module alu_mcycle
    import alu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_op,
    output logic        o_busy,
    output logic [31:0] o_result
);

    mc_state_t   r_state;
    mc_state_t   w_state_next;
    logic [31:0] r_lat_a;
    logic [31:0] r_lat_b;
    logic [2:0]  r_lat_op;
    logic [4:0]  r_count;
    logic [31:0] r_acc;
    logic [31:0] r_work_a;
    logic [31:0] r_work_b;
    logic [31:0] r_result;

    logic        w_start;
    logic        w_match;
    logic        w_is_div;
    logic        w_last;
    logic [32:0] w_rem_shift;
    logic [32:0] w_add_x;
    logic [32:0] w_add_y;
    logic [33:0] w_sum;
    logic        w_qbit;
    logic [31:0] w_rem_next;

    assign w_start  = (i_op == ALU_MUL) || (i_op == ALU_DIV);
    assign w_match  = (i_op == r_lat_op) && (i_a == r_lat_a) && (i_b == r_lat_b);
    assign w_is_div = (r_lat_op == ALU_DIV);
    assign w_last   = (r_count == ALU_LAST_ITER);

    // DIV: remainder-minus-divisor with carry-out as the quotient bit (divisor 0 gives all ones).
    // MUL: accumulator plus multiplicand when the current multiplier bit is set.
    assign w_rem_shift = {r_acc, r_work_a[31]};
    assign w_add_x     = w_is_div ? w_rem_shift : {1'b0, r_acc};
    assign w_add_y     = w_is_div ? ~{1'b0, r_lat_b}
                                  : {1'b0, (r_work_b[0] ? r_work_a : 32'd0)};
    assign w_sum       = {1'b0, w_add_x} + {1'b0, w_add_y} + {33'd0, w_is_div};
    assign w_qbit      = w_sum[33];
    assign w_rem_next  = w_qbit ? w_sum[31:0] : w_rem_shift[31:0];

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_busy = i_op[2] & ~i_op[1];
                if (w_start) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                o_busy = ~w_match;
                if (!w_match) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_lat_a  <= '0;
            r_lat_b  <= '0;
            r_lat_op <= '0;
            r_count  <= '0;
            r_acc    <= '0;
            r_work_a <= '0;
            r_work_b <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_lat_a  <= i_a;
                        r_lat_b  <= i_b;
                        r_lat_op <= i_op;
                        r_count  <= '0;
                        r_acc    <= '0;
                        r_work_a <= i_a;
                        r_work_b <= i_b;
                    end
                end
                ST_RUN: begin
                    r_count <= r_count + 5'd1;
                    if (w_is_div) begin
                        r_acc    <= w_rem_next;
                        r_work_a <= {r_work_a[30:0], w_qbit};
                        if (w_last) r_result <= {r_work_a[30:0], w_qbit};
                    end else begin
                        r_acc    <= w_sum[31:0];
                        r_work_a <= {r_work_a[30:0], 1'b0};
                        r_work_b <= {1'b0, r_work_b[31:1]};
                        if (w_last) r_result <= w_sum[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/alu.sv
// 32-bit datapath ALU: single-cycle ADD/SUB/AND/ORR with NZCV flags, plus
// stalling unsigned MUL/DIV delegated to the iterative engine.
module alu
    import alu_pkg::*;
(
    input  logic        CLK,
    input  logic        MReset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUControl,
    output logic        Busy,
    output logic [31:0] Result,
    output logic [3:0]  ALUFlags
);

    logic        w_mc_busy;
    logic [31:0] w_mc_result;
    logic        w_is_mc;
    logic        w_is_sub;
    logic [31:0] w_addend;
    logic [32:0] w_sum;
    logic        w_c;
    logic        w_v;

    alu_mcycle u_mcycle (
        .i_clk    (CLK),
        .i_rst_n  (MReset),
        .i_a      (A),
        .i_b      (B),
        .i_op     (ALUControl),
        .o_busy   (w_mc_busy),
        .o_result (w_mc_result)
    );

    assign w_is_mc  = (ALUControl == ALU_MUL) || (ALUControl == ALU_DIV);
    assign w_is_sub = (ALUControl == ALU_SUB);
    assign w_addend = w_is_sub ? ~B : B;
    assign w_sum    = {1'b0, A} + {1'b0, w_addend} + {32'd0, w_is_sub};

    // The engine keeps iterating under a combinational opcode, so its stall is masked here.
    assign Busy = w_mc_busy & w_is_mc;

    always_comb begin
        Result   = '0;
        ALUFlags = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        case (ALUControl)
            ALU_ADD, ALU_SUB: begin
                Result = w_sum[31:0];
                w_c    = w_sum[32];
                w_v    = (A[31] == w_addend[31]) && (w_sum[31] != A[31]);
            end
            ALU_AND: Result = A & B;
            ALU_ORR: Result = A | B;
            ALU_MUL, ALU_DIV: Result = w_mc_busy ? 32'd0 : w_mc_result;
            default: Result = '0;
        endcase
        if (!ALUControl[2] || (w_is_mc && !w_mc_busy))
            ALUFlags = {Result[31], (Result == 32'd0), w_c, w_v};
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the ALU: combinational ops, MUL/DIV
// latency, mid-run operand changes and asynchronous reset during RUN.
module tb_alu;

    logic        CLK;
    logic        MReset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUControl;
    logic        Busy;
    logic [31:0] Result;
    logic [3:0]  ALUFlags;

    int n_checks = 0;
    int n_errors = 0;
    int cycles;

    alu dut (
        .CLK        (CLK),
        .MReset     (MReset),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .Busy       (Busy),
        .Result     (Result),
        .ALUFlags   (ALUFlags)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        ALUControl = op;
        A = a;
        B = b;
        #1;
    endtask

    // Counts rising edges until Busy drops, bounded so a stuck engine still ends the run.
    task automatic wait_ready(output int n);
        n = 0;
        while (Busy && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
    endtask

    task automatic show();
        $display("op=%b A=%h B=%h -> Result=%h NZCV=%b Busy=%b",
                 ALUControl, A, B, Result, ALUFlags, Busy);
    endtask

    task automatic comb(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic [3:0] fl);
        apply(op, a, b);
        show();
        chk({tag, "_res"}, Result, res);
        chk({tag, "_flags"}, {28'd0, ALUFlags}, {28'd0, fl});
        chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        MReset     = 1'b0;
        ALUControl = 3'b000;
        A          = 32'd1;
        B          = 32'd2;
        #1;
        chk("rst_add_res", Result, 32'd3);
        chk("rst_add_busy", {31'd0, Busy}, 32'd0);
        ALUControl = 3'b100;
        #1;
        chk("rst_mul_busy", {31'd0, Busy}, 32'd1);
        chk("rst_mul_res", Result, 32'd0);
        chk("rst_mul_flags", {28'd0, ALUFlags}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_hold_busy", {31'd0, Busy}, 32'd1);
        @(negedge CLK);
        ALUControl = 3'b000;
        MReset = 1'b1;
        @(posedge CLK);

        comb("add_ovf", 3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001);
        comb("add_carry", 3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110);
        comb("sub_eq", 3'b001, 32'd5, 32'd5, 32'h00000000, 4'b0110);
        comb("sub_neg", 3'b001, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b1000);
        comb("sub_vovf", 3'b001, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b0011);
        comb("and", 3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000);
        comb("orr", 3'b011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 4'b1000);
        comb("rsv6", 3'b110, 32'h12345678, 32'h0, 32'h0, 4'b0000);
        comb("rsv7", 3'b111, 32'h0, 32'h0, 32'h0, 4'b0000);

        // MUL 2x2 held steady: busy in cycles 0..32, result in cycle 33
        apply(3'b100, 32'd2, 32'd2);
        chk("mul_c0_busy", {31'd0, Busy}, 32'd1);
        chk("mul_c0_res", Result, 32'd0);
        wait_ready(cycles);
        show();
        chk("mul_latency", cycles, 32'd33);
        chk("mul_res", Result, 32'd4);
        chk("mul_flags", {28'd0, ALUFlags}, 32'd0);
        repeat (5) @(posedge CLK);
        #1;
        chk("mul_hold_res", Result, 32'd4);
        chk("mul_hold_busy", {31'd0, Busy}, 32'd0);

        comb("idle_add", 3'b000, 32'd10, 32'd20, 32'd30, 4'b0000);
        @(posedge CLK);
        apply(3'b100, 32'h00010000, 32'h00010003);
        wait_ready(cycles);
        show();
        chk("mul_wrap_res", Result, 32'h00030000);

        comb("idle_add2", 3'b000, 32'd0, 32'd0, 32'd0, 4'b0100);
        @(posedge CLK);
        apply(3'b101, 32'hFFFFFFFE, 32'hFFFFFFFE);
        chk("div_c0_busy", {31'd0, Busy}, 32'd1);
        wait_ready(cycles);
        show();
        chk("div_latency", cycles, 32'd33);
        chk("div_big_res", Result, 32'd1);
        chk("div_big_flags", {28'd0, ALUFlags}, 32'd0);

        comb("idle_add3", 3'b000, 32'd0, 32'd1, 32'd1, 4'b0000);
        @(posedge CLK);
        apply(3'b101, 32'd64, 32'd7);
        wait_ready(cycles);
        show();
        chk("div_64_7_res", Result, 32'd9);

        comb("idle_add4", 3'b000, 32'd0, 32'd1, 32'd1, 4'b0000);
        @(posedge CLK);
        apply(3'b101, 32'd5, 32'd0);
        wait_ready(cycles);
        show();
        chk("div0_res", Result, 32'hFFFFFFFF);
        chk("div0_flags", {28'd0, ALUFlags}, 32'h8);

        // Changing B mid-RUN: first product discarded, restarted product delivered
        comb("idle_add5", 3'b000, 32'd0, 32'd1, 32'd1, 4'b0000);
        @(posedge CLK);
        apply(3'b100, 32'd3, 32'd4);
        repeat (10) @(posedge CLK);
        #1;
        B = 32'd5;
        #1;
        chk("chg_busy", {31'd0, Busy}, 32'd1);
        wait_ready(cycles);
        show();
        chk("chg_restarted", {31'd0, (cycles > 33 && cycles < 200)}, 32'd1);
        chk("chg_res", Result, 32'd15);

        // Combinational opcode mid-RUN is served at once
        comb("idle_add6", 3'b000, 32'd0, 32'd1, 32'd1, 4'b0000);
        @(posedge CLK);
        apply(3'b100, 32'd9, 32'd9);
        repeat (5) @(posedge CLK);
        #1;
        ALUControl = 3'b000;
        A = 32'd1;
        B = 32'd2;
        #1;
        show();
        chk("midrun_add_res", Result, 32'd3);
        chk("midrun_add_busy", {31'd0, Busy}, 32'd0);

        // Reset during RUN, then a full op after release
        repeat (40) @(posedge CLK);
        apply(3'b100, 32'd6, 32'd7);
        repeat (10) @(posedge CLK);
        #1;
        MReset = 1'b0;
        #1;
        chk("rstrun_busy", {31'd0, Busy}, 32'd1);
        chk("rstrun_res", Result, 32'd0);
        @(posedge CLK);
        #1;
        chk("rstrun_busy2", {31'd0, Busy}, 32'd1);
        @(negedge CLK);
        MReset = 1'b1;
        #1;
        wait_ready(cycles);
        show();
        chk("rstrun_latency", cycles, 32'd33);
        chk("rstrun_res_after", Result, 32'd42);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
